// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage access unit (master)
// and the data memory (slave).
interface mem_access_unit_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM ops into one bus request each,
// aligns store lanes, extends load data and stalls the pipeline meanwhile.
package control_types_pkg;
    typedef enum logic [3:0] {
        MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_op_t;
endpackage

module mem_access_unit
    import control_types_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_do_write_ctrl_mem,
    input  mem_op_t                   mem_ctrl_mem,
    input  logic [31:0]               alu_result_mem,
    input  logic [31:0]               mem_data_in_mem,
    mem_access_unit_if.master         dmem,
    output logic [31:0]               load_data_mem,
    output logic                      mem_stall,
    output logic                      misaligned_fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    mem_op_t     op_q;
    logic [1:0]  off_q;

    logic        is_store, is_load, active, misaligned;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, shifted, ext;

    always_comb begin
        is_store   = mem_ctrl_mem inside {MEM_SB, MEM_SH, MEM_SW};
        is_load    = mem_ctrl_mem inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
        active     = is_load | (is_store & mem_do_write_ctrl_mem);
        misaligned = ((mem_ctrl_mem inside {MEM_LH, MEM_LHU, MEM_SH}) & alu_result_mem[0]) |
                     ((mem_ctrl_mem inside {MEM_LW, MEM_SW}) & (alu_result_mem[1:0] != 2'b00));
        be_n    = 4'b1111;
        wdata_n = mem_data_in_mem;
        case (mem_ctrl_mem)
            MEM_SB: begin
                be_n    = 4'b0001 << alu_result_mem[1:0];
                wdata_n = {4{mem_data_in_mem[7:0]}};
            end
            MEM_SH: begin
                be_n    = alu_result_mem[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{mem_data_in_mem[15:0]}};
            end
            default: ;
        endcase
    end

    // Byte lane selected by the latched offset lands in bits [7:0]/[15:0].
    always_comb begin
        shifted = dmem.dmem_resp_rdata >> {off_q, 3'b000};
        case (op_q)
            MEM_LB:  ext = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: ext = {24'd0, shifted[7:0]};
            MEM_LH:  ext = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LHU: ext = {16'd0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // Stall is combinational on the incoming op so the pipeline freezes the
    // very cycle an access first shows up.
    assign mem_stall = ((state == IDLE) & active) | (state == REQ) | (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            op_q                <= MEM_NOP;
            off_q               <= 2'b00;
            dmem.dmem_req_valid <= 1'b0;
            dmem.dmem_req_we    <= 1'b0;
            dmem.dmem_req_addr  <= 32'd0;
            dmem.dmem_req_wdata <= 32'd0;
            dmem.dmem_req_be    <= 4'd0;
            load_data_mem       <= 32'd0;
            misaligned_fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (active) begin
                    op_q  <= mem_ctrl_mem;
                    off_q <= alu_result_mem[1:0];
                    if (misaligned) begin
                        state            <= DONE;
                        misaligned_fault <= 1'b1;
                        load_data_mem    <= 32'd0;
                    end else begin
                        state               <= REQ;
                        dmem.dmem_req_valid <= 1'b1;
                        dmem.dmem_req_we    <= is_store;
                        dmem.dmem_req_addr  <= {alu_result_mem[31:2], 2'b00};
                        dmem.dmem_req_wdata <= wdata_n;
                        dmem.dmem_req_be    <= be_n;
                    end
                end
                REQ: if (dmem.dmem_req_ready) begin
                    dmem.dmem_req_valid <= 1'b0;
                    state               <= dmem.dmem_req_we ? DONE : WAIT;
                end
                WAIT: if (dmem.dmem_resp_valid) begin
                    load_data_mem <= ext;
                    state         <= DONE;
                end
                DONE: begin
                    misaligned_fault <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
